// File: rtl/axis_wdup_pack.sv
// -----------------------------------------------------------------------------
// axis_wdup_pack
//
// Narrow-to-wide AXI-Stream packer for the RX sample path. RATIO input samples
// of IN_WIDTH bits are gathered into one output word, LSB lane first. A partial
// word is flushed on s_rx_tlast. Output tlast is raised on an input tlast or
// when the programmable burst length (cfg_burst_len + 1 words) is reached.
//
// The accumulator and the output register form a two-deep buffer. This lets
// the block accept one sample per cycle while m_tx_tready is high. If the
// output stalls, one completed word can wait in the accumulator. s_rx_tready
// comes straight from a register, so it never depends on m_tx_tready through
// combinational logic.
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   cfg_burst_len  words per packet minus 1, sampled at each packet start
//   s_rx_tdata     input sample
//   s_rx_tvalid    input valid
//   s_rx_tlast     input end of packet, flushes a partial word
//   s_rx_tready    input ready (registered)
//   m_tx_tdata     packed word, lane k = [k*IN_WIDTH +: IN_WIDTH]
//   m_tx_tkeep     per-lane valid
//   m_tx_tlast     last word of packet
//   m_tx_tvalid    output valid
//   m_tx_tready    output ready
//
// Accumulator states
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ACC_OPEN | filling lanes; s_rx_tready = 1
//   ACC_HELD | completed word waiting for the output register; tready = 0
// -----------------------------------------------------------------------------
module axis_wdup_pack #(
    parameter int IN_WIDTH   = 16,
    parameter int RATIO      = 4,
    parameter int BURST_BITS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BURST_BITS-1:0]     cfg_burst_len,
    input  logic [IN_WIDTH-1:0]       s_rx_tdata,
    input  logic                      s_rx_tvalid,
    input  logic                      s_rx_tlast,
    output logic                      s_rx_tready,
    output logic [IN_WIDTH*RATIO-1:0] m_tx_tdata,
    output logic [RATIO-1:0]          m_tx_tkeep,
    output logic                      m_tx_tlast,
    output logic                      m_tx_tvalid,
    input  logic                      m_tx_tready
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int LANE_BITS = $clog2(RATIO);
    localparam logic [LANE_BITS-1:0] LANE_MAX = LANE_BITS'(RATIO - 1);

    typedef enum logic {
        ACC_OPEN = 1'b0,
        ACC_HELD = 1'b1
    } acc_state_e;

    acc_state_e              state_q, state_d;
    logic [LANE_BITS-1:0]    lane_q, lane_d;
    logic [OUT_WIDTH-1:0]    acc_data_q, acc_data_d;
    logic [RATIO-1:0]        acc_keep_q, acc_keep_d;
    logic                    acc_inlast_q, acc_inlast_d;
    logic [BURST_BITS-1:0]   word_cnt_q, word_cnt_d;
    logic [BURST_BITS-1:0]   burst_len_q, burst_len_d;
    logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
    logic [RATIO-1:0]        out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;
    logic                    out_valid_q, out_valid_d;

    logic                    acc_full;
    logic                    accept;
    logic                    completing;
    logic                    out_free;
    logic                    xfer;
    logic [OUT_WIDTH-1:0]    fill_data;
    logic [RATIO-1:0]        fill_keep;
    logic [OUT_WIDTH-1:0]    word_data;
    logic [RATIO-1:0]        word_keep;
    logic                    word_inlast;
    logic                    word_last;
    logic [BURST_BITS-1:0]   blen_eff;

    assign acc_full    = (state_q == ACC_HELD);
    assign s_rx_tready = !acc_full;
    assign accept      = s_rx_tvalid && !acc_full;
    assign completing  = accept && ((lane_q == LANE_MAX) || s_rx_tlast);
    assign out_free    = !out_valid_q || m_tx_tready;
    assign xfer        = (acc_full || completing) && out_free;

    // Accumulator contents with the incoming sample merged into its lane.
    always_comb begin
        fill_data = acc_data_q;
        fill_keep = acc_keep_q;
        for (int k = 0; k < RATIO; k++) begin
            if (lane_q == LANE_BITS'(k)) begin
                fill_data[k*IN_WIDTH +: IN_WIDTH] = s_rx_tdata;
                fill_keep[k]                      = 1'b1;
            end
        end
    end

    // A held word was completed earlier; otherwise the word is completing now.
    assign word_data   = acc_full ? acc_data_q   : fill_data;
    assign word_keep   = acc_full ? acc_keep_q   : fill_keep;
    assign word_inlast = acc_full ? acc_inlast_q : s_rx_tlast;

    // At a packet start, cfg_burst_len takes effect for this first word.
    assign blen_eff  = (word_cnt_q == '0) ? cfg_burst_len : burst_len_q;
    assign word_last = word_inlast || (word_cnt_q == blen_eff);

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        acc_data_d   = acc_data_q;
        acc_keep_d   = acc_keep_q;
        acc_inlast_d = acc_inlast_q;
        word_cnt_d   = word_cnt_q;
        burst_len_d  = burst_len_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;

        case (state_q)
            ACC_OPEN: begin
                if (accept) begin
                    acc_data_d = fill_data;
                    if (completing) begin
                        lane_d = '0;
                        if (xfer) begin
                            acc_keep_d = '0;
                        end else begin
                            // Keep the finished word until the output register frees up.
                            acc_keep_d   = fill_keep;
                            acc_inlast_d = s_rx_tlast;
                            state_d      = ACC_HELD;
                        end
                    end else begin
                        lane_d     = lane_q + 1'b1;
                        acc_keep_d = fill_keep;
                    end
                end
            end
            ACC_HELD: begin
                if (xfer) begin
                    acc_keep_d = '0;
                    state_d    = ACC_OPEN;
                end
            end
            default: begin
                state_d = ACC_OPEN;
            end
        endcase

        if (xfer) begin
            out_data_d  = word_data;
            out_keep_d  = word_keep;
            out_last_d  = word_last;
            out_valid_d = 1'b1;
            if (word_cnt_q == '0) begin
                burst_len_d = cfg_burst_len;
            end
            word_cnt_d = word_last ? '0 : word_cnt_q + 1'b1;
        end else if (out_valid_q && m_tx_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC_OPEN;
            lane_q      <= '0;
            acc_keep_q  <= '0;
            word_cnt_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            acc_keep_q  <= acc_keep_d;
            word_cnt_q  <= word_cnt_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Payload registers carry no reset; the valid and keep flags qualify them.
    always_ff @(posedge clk) begin
        acc_data_q   <= acc_data_d;
        acc_inlast_q <= acc_inlast_d;
        burst_len_q  <= burst_len_d;
        out_data_q   <= out_data_d;
    end

    assign m_tx_tdata  = out_data_q;
    assign m_tx_tkeep  = out_keep_q;
    assign m_tx_tlast  = out_last_q;
    assign m_tx_tvalid = out_valid_q;

`ifndef SYNTHESIS
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (m_tx_tvalid && !m_tx_tready) |=>
            (m_tx_tvalid && $stable(m_tx_tdata) && $stable(m_tx_tkeep) && $stable(m_tx_tlast)));

    a_lane_range: assert property (@(posedge clk) disable iff (rst)
        lane_q <= LANE_MAX);

    a_ready_full: assert property (@(posedge clk) disable iff (rst)
        !s_rx_tready |-> acc_full);
`endif

endmodule

// File: tb/tb_axis_wdup_pack.sv
module tb_axis_wdup_pack;

    localparam int IW = 16;
    localparam int R  = 4;
    localparam int BB = 8;
    localparam int OW = IW * R;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BB-1:0] cfg_burst_len = '0;
    logic [IW-1:0] s_rx_tdata = '0;
    logic          s_rx_tvalid = 1'b0;
    logic          s_rx_tlast = 1'b0;
    logic          s_rx_tready;
    logic [OW-1:0] m_tx_tdata;
    logic [R-1:0]  m_tx_tkeep;
    logic          m_tx_tlast;
    logic          m_tx_tvalid;
    logic          m_tx_tready = 1'b0;

    always #5 clk = ~clk;

    axis_wdup_pack #(.IN_WIDTH(IW), .RATIO(R), .BURST_BITS(BB)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_burst_len(cfg_burst_len),
        .s_rx_tdata   (s_rx_tdata),
        .s_rx_tvalid  (s_rx_tvalid),
        .s_rx_tlast   (s_rx_tlast),
        .s_rx_tready  (s_rx_tready),
        .m_tx_tdata   (m_tx_tdata),
        .m_tx_tkeep   (m_tx_tkeep),
        .m_tx_tlast   (m_tx_tlast),
        .m_tx_tvalid  (m_tx_tvalid),
        .m_tx_tready  (m_tx_tready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [OW-1:0] data;
        logic [R-1:0]  keep;
        logic          last;
    } word_t;

    word_t         exp_q[$];
    logic [IW-1:0] cur[$];
    int            m_cnt  = 0;
    int            m_blen = 0;

    task automatic model_accept(input logic [IW-1:0] d, input logic last);
        word_t w;
        cur.push_back(d);
        if (cur.size() == R || last) begin
            w.data = '0;
            w.keep = '0;
            foreach (cur[i]) begin
                w.data[i*IW +: IW] = cur[i];
                w.keep[i]          = 1'b1;
            end
            if (m_cnt == 0) m_blen = int'(cfg_burst_len);
            w.last = last || (m_cnt == m_blen);
            m_cnt  = w.last ? 0 : m_cnt + 1;
            exp_q.push_back(w);
            cur.delete();
        end
    endtask

    // ---------------- output ready driver ----------------
    // 0: always ready, 1: never ready, 2: random 50%
    int rdy_mode = 0;
    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       m_tx_tready = 1'b1;
                1:       m_tx_tready = 1'b0;
                default: m_tx_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    int            cyc = 0;
    int            hs_cyc[$];
    logic          prev_stall = 1'b0;
    logic [OW-1:0] sv_data;
    logic [R-1:0]  sv_keep;
    logic          sv_last;

    initial begin
        word_t         w;
        logic [OW-1:0] mask;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(m_tx_tvalid), 64'd1);
                    chk("stall_data",  64'(m_tx_tdata), 64'(sv_data));
                    chk("stall_keep",  64'(m_tx_tkeep), 64'(sv_keep));
                    chk("stall_last",  64'(m_tx_tlast), 64'(sv_last));
                end
                if (m_tx_tvalid && m_tx_tready) begin
                    hs_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h, expected no word", m_tx_tdata);
                    end else begin
                        w = exp_q.pop_front();
                        mask = '0;
                        for (int k = 0; k < R; k++)
                            if (m_tx_tkeep[k]) mask[k*IW +: IW] = '1;
                        chk("word_data", 64'(m_tx_tdata & mask), 64'(w.data));
                        chk("word_keep", 64'(m_tx_tkeep), 64'(w.keep));
                        chk("word_last", 64'(m_tx_tlast), 64'(w.last));
                    end
                end
                prev_stall = m_tx_tvalid && !m_tx_tready;
                sv_data    = m_tx_tdata;
                sv_keep    = m_tx_tkeep;
                sv_last    = m_tx_tlast;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [IW-1:0] d, input logic last, input bit rnd, output int tries);
        bit done = 0;
        tries = 0;
        while (!done) begin
            @(negedge clk);
            if (rnd && ($urandom_range(0, 1) == 0)) begin
                s_rx_tvalid = 1'b0;
            end else begin
                s_rx_tvalid = 1'b1;
                s_rx_tdata  = d;
                s_rx_tlast  = last;
                tries++;
                if (s_rx_tready) begin
                    model_accept(d, last);
                    done = 1;
                end
            end
            if (!done && tries > 3000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no accept, expected accept within 3000 cycles");
                done = 1;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        s_rx_tvalid = 1'b0;
        s_rx_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_s_ready", 64'(s_rx_tready), 64'd1);
        chk("rst_m_valid", 64'(m_tx_tvalid), 64'd0);
        chk("rst_m_last",  64'(m_tx_tlast),  64'd0);
        chk("rst_m_keep",  64'(m_tx_tkeep),  64'd0);
        rst = 1'b0;
        cur.delete();
        m_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- tests ----------------
    initial begin
        int t;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_s_ready", 64'(s_rx_tready), 64'd1);
        chk("rst_m_valid", 64'(m_tx_tvalid), 64'd0);
        chk("rst_m_last",  64'(m_tx_tlast),  64'd0);
        chk("rst_m_keep",  64'(m_tx_tkeep),  64'd0);
        rst = 1'b0;

        // 1: continuous stream, burst of 2 words
        cfg_burst_len = 8'd1;
        for (int i = 1; i <= 8; i++) begin
            send(16'(i), 1'b0, 1'b0, t);
            chk("t1_no_stall", 64'(t), 64'd1);
        end
        idle();
        wait_drain();

        // 2: partial word flushed by tlast, then a full word from lane 0
        send(16'h000A, 1'b0, 1'b0, t);
        send(16'h000B, 1'b0, 1'b0, t);
        send(16'h000C, 1'b1, 1'b0, t);
        for (int i = 0; i < 4; i++) send(16'h00D0 + 16'(i), 1'b0, 1'b0, t);
        idle();
        wait_drain();

        // 3: output stalled, accumulator fills, then release
        @(posedge clk);
        rdy_mode = 1;
        hs_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            send(16'h3000 + 16'(i), 1'b0, 1'b0, t);
            chk("t3_no_stall", 64'(t), 64'd1);
        end
        fork
            begin
                int t2;
                for (int i = 8; i < 12; i++) send(16'h3000 + 16'(i), 1'b0, 1'b0, t2);
            end
            begin
                @(negedge clk);
                #1;
                chk("t3_ready_dropped", 64'(s_rx_tready), 64'd0);
                repeat (3) @(negedge clk);
                @(posedge clk);
                rdy_mode = 0;
                @(negedge clk);
                #1;
                chk("t3_ready_held", 64'(s_rx_tready), 64'd0);
                @(negedge clk);
                #1;
                chk("t3_ready_back", 64'(s_rx_tready), 64'd1);
            end
        join
        idle();
        wait_drain();
        chk("t3_hs_count", 64'(hs_cyc.size() >= 2), 64'd1);
        if (hs_cyc.size() >= 2)
            chk("t3_back_to_back", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);

        // 4: random valid/ready
        cfg_burst_len = 8'd3;
        @(posedge clk);
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) send(16'($urandom), 1'b0, 1'b1, t);
        idle();
        @(posedge clk);
        rdy_mode = 0;
        wait_drain();

        // 5: burst length change mid-packet
        do_reset();
        cfg_burst_len = 8'd2;
        for (int i = 0; i < 4; i++) send(16'h5000 + 16'(i), 1'b0, 1'b0, t);
        idle();
        cfg_burst_len = 8'd0;
        for (int i = 4; i < 20; i++) send(16'h5000 + 16'(i), 1'b0, 1'b0, t);
        idle();
        wait_drain();

        // 6: reset with a partial accumulator
        cfg_burst_len = 8'd3;
        send(16'h6001, 1'b0, 1'b0, t);
        send(16'h6002, 1'b0, 1'b0, t);
        idle();
        do_reset();
        for (int i = 0; i < 4; i++) send(16'h6100 + 16'(i), 1'b0, 1'b0, t);
        idle();
        wait_drain();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
